zx81_video_gen: RTL and testbench

ZX81_VIDEO_GEN -- requirements
Module: zx81_video_gen

---
 rtl/zx81_video_gen.sv | 182 ++++++++++++++++++
 tb/tb_zx81_video_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/zx81_video_gen.sv
// ZX80/ZX81 video generator: line timing, NMI/wait generation, vsync with
// timeout, character row counter, pixel shifter and back-porch blanking.
module zx81_video_gen #(
    parameter int LINE_CYCLES = 207,
    parameter int HS_START    = 16,
    parameter int HS_END      = 31,
    parameter int ROW_BITS    = 3,
    parameter int BP_BITS     = 5,
    parameter int VS_MAX      = 4096
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                ce_cpu_p,
    input  logic                ce_cpu_n,
    input  logic                ce_pix,
    input  logic                zx81,
    input  logic                inv_opt,
    input  logic                iorq_n,
    input  logic                mreq_n,
    input  logic                rd_n,
    input  logic                wr_n,
    input  logic                m1_n,
    input  logic                rfsh_n,
    input  logic                halt_n,
    input  logic [15:0]         addr,
    input  logic [7:0]          mem_data,
    output logic                nmi_n,
    output logic                wait_n,
    output logic                nop_force,
    output logic [5:0]          char_code,
    output logic [ROW_BITS-1:0] row,
    output logic                csync,
    output logic                vsync_n,
    output logic                video_out,
    output logic                vs_timeout
);

    localparam int CNT_W = $clog2(LINE_CYCLES);
    localparam int VT_W  = $clog2(VS_MAX + 1);

    logic [CNT_W-1:0]    count_q, count_d;
    logic                nmi_latch_q, nmi_latch_d;
    logic                vsync_n_q, vsync_n_d;
    logic [VT_W-1:0]     vs_timer_q, vs_timer_d;
    logic                vs_timeout_q, vs_timeout_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [7:0]          latch_q, latch_d;
    logic                nop_store_q, nop_store_d;
    logic [7:0]          shifter_q, shifter_d;
    logic                inverse_q, inverse_d;
    logic [BP_BITS-1:0]  bp_q, bp_d;
    logic                csync_prev_q, vsync_prev_q, start_prev_q;

    logic hsync_n, gate, nopgen, start, load;
    logic addr_unused;

    // Only the top bit and the two port-select bits of the address matter here.
    assign addr_unused = ^addr[14:2];

    assign hsync_n   = ~((count_q >= CNT_W'(HS_START)) && (count_q <= CNT_W'(HS_END)));
    assign nmi_n     = ~(zx81 & nmi_latch_q & ~hsync_n);
    assign wait_n    = ~(zx81 & halt_n & ~nmi_n);
    assign gate      = ~zx81 | ~nmi_latch_q;
    assign csync     = vsync_n_q & hsync_n;
    assign nopgen    = addr[15] & ~mem_data[6] & halt_n;
    assign nop_force = ~m1_n & nopgen;
    assign start     = mreq_n & nop_store_q & ce_cpu_p & gate;
    assign load      = start & ~start_prev_q;

    assign char_code  = latch_q[5:0];
    assign row        = row_q;
    assign vsync_n    = vsync_n_q;
    assign vs_timeout = vs_timeout_q;
    assign video_out  = (~inv_opt ^ shifter_q[7] ^ inverse_q) & (bp_q == '0) & csync;

    always_comb begin
        count_d      = count_q;
        nmi_latch_d  = nmi_latch_q;
        vsync_n_d    = vsync_n_q;
        vs_timer_d   = vs_timer_q;
        vs_timeout_d = vs_timeout_q;
        row_d        = row_q;
        latch_d      = latch_q;
        nop_store_d  = nop_store_q;
        shifter_d    = shifter_q;
        inverse_d    = inverse_q;
        bp_d         = bp_q;

        if (ce_cpu_n) begin
            if (!m1_n && !iorq_n)
                count_d = '0;
            else if (count_q == CNT_W'(LINE_CYCLES - 1))
                count_d = '0;
            else
                count_d = count_q + 1'b1;
        end

        if (zx81 && !iorq_n && !wr_n && (addr[0] ^ addr[1]))
            nmi_latch_d = addr[1];

        if (gate && !iorq_n && !wr_n)
            vsync_n_d = 1'b1;
        else if (gate && !iorq_n && !rd_n && !addr[0])
            vsync_n_d = 1'b0;

        if (vsync_prev_q && !vsync_n_q)
            vs_timeout_d = 1'b0;

        // Forced release is evaluated last so it overrides a keyboard-read assert.
        if (vsync_n_q) begin
            vs_timer_d = '0;
        end else if (ce_cpu_n) begin
            if (vs_timer_q == VT_W'(VS_MAX - 1)) begin
                vs_timer_d   = VT_W'(VS_MAX);
                vsync_n_d    = 1'b1;
                vs_timeout_d = 1'b1;
            end else begin
                vs_timer_d = vs_timer_q + 1'b1;
            end
        end

        if (!vsync_n_q)
            row_d = '0;
        else if (csync_prev_q && !csync)
            row_d = row_q + 1'b1;

        if (rfsh_n && !mreq_n && ce_cpu_n) begin
            latch_d     = mem_data;
            nop_store_d = nopgen;
        end

        if (load)
            shifter_d = nop_force ? 8'h00 : mem_data;
        else if (ce_pix)
            shifter_d = {shifter_q[6:0], 1'b0};

        if (load)
            inverse_d = latch_q[7];
        else if (mreq_n && ce_cpu_p)
            inverse_d = 1'b0;

        if (!csync_prev_q && csync)
            bp_d = BP_BITS'(1);
        else if ((bp_q != '0) && ce_pix)
            bp_d = bp_q + 1'b1;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            count_q      <= '0;
            nmi_latch_q  <= 1'b0;
            vsync_n_q    <= 1'b1;
            vs_timer_q   <= '0;
            vs_timeout_q <= 1'b0;
            row_q        <= '0;
            latch_q      <= 8'h00;
            nop_store_q  <= 1'b0;
            shifter_q    <= 8'h00;
            inverse_q    <= 1'b0;
            bp_q         <= BP_BITS'(1);
            csync_prev_q <= 1'b1;
            vsync_prev_q <= 1'b1;
            start_prev_q <= 1'b1;
        end else begin
            count_q      <= count_d;
            nmi_latch_q  <= nmi_latch_d;
            vsync_n_q    <= vsync_n_d;
            vs_timer_q   <= vs_timer_d;
            vs_timeout_q <= vs_timeout_d;
            row_q        <= row_d;
            latch_q      <= latch_d;
            nop_store_q  <= nop_store_d;
            shifter_q    <= shifter_d;
            inverse_q    <= inverse_d;
            bp_q         <= bp_d;
            csync_prev_q <= csync;
            vsync_prev_q <= vsync_n_q;
            start_prev_q <= start;
        end
    end

endmodule

// File: tb/tb_zx81_video_gen.sv
// Directed bench for zx81_video_gen: line timing, NMI window, vsync timeout,
// pixel shifter, NOP forcing and reset behaviour.
module tb_zx81_video_gen;

    localparam int VS_MAX = 4096;

    logic        clk_sys = 1'b0;
    logic        reset, ce_cpu_p, ce_cpu_n, ce_pix, zx81, inv_opt;
    logic        iorq_n, mreq_n, rd_n, wr_n, m1_n, rfsh_n, halt_n;
    logic [15:0] addr;
    logic [7:0]  mem_data;
    logic        nmi_n, wait_n, nop_force, csync, vsync_n, video_out, vs_timeout;
    logic [5:0]  char_code;
    logic [2:0]  row;

    int checks = 0;
    int errors = 0;
    logic [7:0] pat;

    zx81_video_gen dut (
        .clk_sys(clk_sys), .reset(reset), .ce_cpu_p(ce_cpu_p), .ce_cpu_n(ce_cpu_n),
        .ce_pix(ce_pix), .zx81(zx81), .inv_opt(inv_opt), .iorq_n(iorq_n),
        .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .rfsh_n(rfsh_n),
        .halt_n(halt_n), .addr(addr), .mem_data(mem_data), .nmi_n(nmi_n),
        .wait_n(wait_n), .nop_force(nop_force), .char_code(char_code), .row(row),
        .csync(csync), .vsync_n(vsync_n), .video_out(video_out), .vs_timeout(vs_timeout)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            ce_cpu_n = 1'b1; tick();
            ce_cpu_n = 1'b0; tick();
        end
    endtask

    task automatic pix(input int n);
        for (int i = 0; i < n; i++) begin
            ce_pix = 1'b1; tick();
            ce_pix = 1'b0; tick();
        end
    endtask

    task automatic io_write(input logic [15:0] a);
        addr = a; iorq_n = 1'b0; wr_n = 1'b0; tick();
        iorq_n = 1'b1; wr_n = 1'b1; addr = 16'h0000; tick();
    endtask

    task automatic kbd_read();
        addr = 16'h00FE; iorq_n = 1'b0; rd_n = 1'b0; tick();
        iorq_n = 1'b1; rd_n = 1'b1; addr = 16'h0000; tick();
    endtask

    task automatic latch_char(input logic [15:0] a, input logic [7:0] d);
        addr = a; mem_data = d; mreq_n = 1'b0; rfsh_n = 1'b1;
        pulses(1);
        mreq_n = 1'b1;
    endtask

    task automatic load_p(input logic [15:0] a, input logic [7:0] d);
        addr = a; mem_data = d; mreq_n = 1'b1;
        ce_cpu_p = 1'b1; tick();
        ce_cpu_p = 1'b0; tick();
    endtask

    initial begin
        reset = 1'b0; ce_cpu_p = 1'b0; ce_cpu_n = 1'b0; ce_pix = 1'b0;
        zx81 = 1'b0; inv_opt = 1'b0; iorq_n = 1'b1; mreq_n = 1'b1;
        rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; rfsh_n = 1'b1; halt_n = 1'b1;
        addr = 16'h0000; mem_data = 8'h00;

        // Reset state
        tick(); tick();
        reset = 1'b1; tick();
        chk("rst_nmi_n", nmi_n, 1);
        chk("rst_wait_n", wait_n, 1);
        chk("rst_csync", csync, 1);
        chk("rst_video", video_out, 0);
        chk("rst_vsync_n", vsync_n, 1);
        chk("rst_vs_timeout", vs_timeout, 0);
        chk("rst_row", row, 0);
        chk("rst_char", char_code, 0);

        // Line counter and hsync window, ZX80 mode
        pulses(15); chk("hs_cnt15", csync, 1);
        pulses(1);  chk("hs_cnt16", csync, 0);
        chk("hs_nmi_zx80", nmi_n, 1);
        chk("row_after_line1", row, 1);
        pulses(15); chk("hs_cnt31", csync, 0);
        pulses(1);  chk("hs_cnt32", csync, 1);
        pulses(68);
        m1_n = 1'b0; iorq_n = 1'b0;
        pulses(1);
        m1_n = 1'b1; iorq_n = 1'b1;
        chk("ack_cnt0", csync, 1);
        pulses(15); chk("ack_cnt15", csync, 1);
        pulses(1);  chk("ack_cnt16", csync, 0);
        chk("row_after_ack", row, 2);
        pulses(191); chk("wrap_cnt0", csync, 1);
        pulses(15); chk("wrap_cnt15", csync, 1);
        pulses(1);  chk("wrap_cnt16", csync, 0);
        chk("row_after_wrap", row, 3);

        // ZX81 NMI window (now at count 16)
        zx81 = 1'b1;
        io_write(16'h00FE);
        chk("nmi_cnt16", nmi_n, 0);
        chk("wait_cnt16", wait_n, 0);
        halt_n = 1'b0; #1;
        chk("wait_halted", wait_n, 1);
        halt_n = 1'b1; #1;
        pulses(15); chk("nmi_cnt31", nmi_n, 0);
        pulses(1);  chk("nmi_cnt32", nmi_n, 1);
        chk("wait_cnt32", wait_n, 1);
        pulses(190); chk("nmi_next15", nmi_n, 1);
        pulses(1);   chk("nmi_next16", nmi_n, 0);
        io_write(16'h00FD);
        chk("nmi_latch_clr", nmi_n, 1);

        // Vsync and timeout, ZX80 mode
        zx81 = 1'b0;
        kbd_read();
        chk("vs_assert", vsync_n, 0);
        chk("vs_row_hold", row, 0);
        chk("vs_csync", csync, 0);
        pulses(VS_MAX - 1);
        chk("vs_before_max", vsync_n, 0);
        chk("vs_to_before", vs_timeout, 0);
        pulses(1);
        chk("vs_forced", vsync_n, 1);
        chk("vs_to_set", vs_timeout, 1);
        kbd_read();
        chk("vs_reassert", vsync_n, 0);
        chk("vs_to_clr", vs_timeout, 0);
        pulses(VS_MAX - 1);
        addr = 16'h00FE; iorq_n = 1'b0; rd_n = 1'b0; ce_cpu_n = 1'b1; tick();
        iorq_n = 1'b1; rd_n = 1'b1; ce_cpu_n = 1'b0; addr = 16'h0000; tick();
        chk("vs_force_beats_kbd", vsync_n, 1);
        chk("vs_to_set2", vs_timeout, 1);

        // Shifter with inverse attribute
        reset = 1'b0; tick(); reset = 1'b1;
        latch_char(16'hC000, 8'h88);
        chk("char_88", char_code, 6'h08);
        pix(30); chk("bp_active", video_out, 0);
        pix(1);  chk("bp_expired", video_out, 1);
        m1_n = 1'b1;
        load_p(16'hC000, 8'hAA);
        chk("nopf_m1_high", nop_force, 0);
        pat = 8'b1010_1010;
        chk("pix0", video_out, 1);
        for (int i = 1; i < 8; i++) begin
            pix(1);
            chk($sformatf("pix%0d", i), video_out, {15'd0, pat[7-i]});
        end
        pix(1); chk("pix_empty_inv", video_out, 0);

        // Inverse cleared by a non-loading ce_cpu_p
        latch_char(16'h0000, 8'h80);
        chk("char_00", char_code, 6'h00);
        load_p(16'h0000, 8'h00);
        chk("inv_cleared", video_out, 1);

        // NOP-forced load
        latch_char(16'hC000, 8'h05);
        chk("char_05", char_code, 6'h05);
        load_p(16'h0000, 8'h00);
        chk("pre_nop_video", video_out, 1);
        m1_n = 1'b0; addr = 16'hC000; mem_data = 8'hB3; #1;
        chk("nopf_set", nop_force, 1);
        halt_n = 1'b0; #1;
        chk("nopf_halt", nop_force, 0);
        halt_n = 1'b1; #1;
        load_p(16'hC000, 8'hB3);
        m1_n = 1'b1; #1;
        chk("nop_white", video_out, 1);
        chk("nopf_clear", nop_force, 0);

        // Reset during vsync and NMI window (count is 3 here)
        zx81 = 1'b1;
        io_write(16'h00FE);
        zx81 = 1'b0;
        kbd_read();
        zx81 = 1'b1;
        pulses(13);
        chk("pre_rst_nmi", nmi_n, 0);
        chk("pre_rst_vs", vsync_n, 0);
        reset = 1'b0; tick();
        chk("mid_rst_vs", vsync_n, 1);
        chk("mid_rst_nmi", nmi_n, 1);
        chk("mid_rst_row", row, 0);
        chk("mid_rst_csync", csync, 1);
        chk("mid_rst_video", video_out, 0);
        chk("mid_rst_char", char_code, 0);
        reset = 1'b1;
        pulses(16);
        chk("post_rst_nmi", nmi_n, 1);
        chk("post_rst_hs", csync, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
